// File: rtl/legv8_control_unit_pkg.sv
// Shared definitions for the LEGv8 control unit: opcodes, ALU/PC
// select codes, sequencer states and the control word layout.
package legv8_control_unit_pkg;

    localparam int CW_W   = 94;
    localparam int INST_W = 32;

    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_ADDS = 11'h558;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_SUBS = 11'h758;
    localparam logic [10:0] OPC_AND  = 11'h450;
    localparam logic [10:0] OPC_ANDS = 11'h750;
    localparam logic [10:0] OPC_ORR  = 11'h550;
    localparam logic [10:0] OPC_EOR  = 11'h650;
    localparam logic [10:0] OPC_LSL  = 11'h69B;
    localparam logic [10:0] OPC_LSR  = 11'h69A;
    localparam logic [10:0] OPC_BR   = 11'h6B0;
    localparam logic [10:0] OPC_STUR = 11'h7C0;
    localparam logic [10:0] OPC_LDUR = 11'h7C2;

    localparam logic [9:0] OPC_ADDI  = 10'h244;
    localparam logic [9:0] OPC_ADDIS = 10'h2C4;
    localparam logic [9:0] OPC_SUBI  = 10'h344;
    localparam logic [9:0] OPC_SUBIS = 10'h3C4;
    localparam logic [9:0] OPC_ANDI  = 10'h248;
    localparam logic [9:0] OPC_ORRI  = 10'h2C8;
    localparam logic [9:0] OPC_EORI  = 10'h348;

    localparam logic [7:0] OPC_CBZ   = 8'hB4;
    localparam logic [7:0] OPC_CBNZ  = 8'hB5;
    localparam logic [7:0] OPC_BCOND = 8'h54;

    localparam logic [5:0] OPC_B  = 6'h05;
    localparam logic [5:0] OPC_BL = 6'h25;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_PC4  = 2'b01;
    localparam logic [1:0] PS_PCK  = 2'b10;
    localparam logic [1:0] PS_PCA  = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_LOAD2 = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    typedef enum logic [4:0] {
        OP_BAD, OP_ADD, OP_ADDS, OP_SUB, OP_SUBS,
        OP_AND, OP_ANDS, OP_ORR, OP_EOR,
        OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
        OP_ANDI, OP_ORRI, OP_EORI,
        OP_LSL, OP_LSR, OP_LDUR, OP_STUR,
        OP_B, OP_BL, OP_BR, OP_CBZ, OP_CBNZ, OP_BCOND
    } op_e;

    typedef struct packed {
        logic [63:0] constant;
        logic        en_pc;
        logic        en_mem;
        logic        en_alu;
        logic        pcsel;
        logic        bsel;
        logic        sl;
        logic        wm;
        logic        wr;
        logic [1:0]  ps;
        logic [4:0]  fs;
        logic [4:0]  sb;
        logic [4:0]  sa;
        logic [4:0]  da;
    } cw_t;

    // Longer opcodes are matched last so they win over shorter prefixes.
    function automatic op_e decode_op(input logic [31:0] ir);
        op_e op;
        op = OP_BAD;
        case (ir[31:26])
            OPC_B:   op = OP_B;
            OPC_BL:  op = OP_BL;
            default: ;
        endcase
        case (ir[31:24])
            OPC_CBZ:   op = OP_CBZ;
            OPC_CBNZ:  op = OP_CBNZ;
            OPC_BCOND: op = OP_BCOND;
            default:   ;
        endcase
        case (ir[31:22])
            OPC_ADDI:  op = OP_ADDI;
            OPC_ADDIS: op = OP_ADDIS;
            OPC_SUBI:  op = OP_SUBI;
            OPC_SUBIS: op = OP_SUBIS;
            OPC_ANDI:  op = OP_ANDI;
            OPC_ORRI:  op = OP_ORRI;
            OPC_EORI:  op = OP_EORI;
            default:   ;
        endcase
        case (ir[31:21])
            OPC_ADD:  op = OP_ADD;
            OPC_ADDS: op = OP_ADDS;
            OPC_SUB:  op = OP_SUB;
            OPC_SUBS: op = OP_SUBS;
            OPC_AND:  op = OP_AND;
            OPC_ANDS: op = OP_ANDS;
            OPC_ORR:  op = OP_ORR;
            OPC_EOR:  op = OP_EOR;
            OPC_LSL:  op = OP_LSL;
            OPC_LSR:  op = OP_LSR;
            OPC_BR:   op = OP_BR;
            OPC_STUR: op = OP_STUR;
            OPC_LDUR: op = OP_LDUR;
            default:  ;
        endcase
        return op;
    endfunction

    function automatic logic [4:0] alu_fs(input op_e op);
        logic [4:0] fs;
        fs = FS_AND;
        case (op)
            OP_ADD, OP_ADDS, OP_ADDI, OP_ADDIS,
            OP_LDUR, OP_STUR:               fs = FS_ADD;
            OP_SUB, OP_SUBS, OP_SUBI,
            OP_SUBIS:                       fs = FS_SUB;
            OP_ORR, OP_ORRI, OP_CBZ,
            OP_CBNZ:                        fs = FS_OR;
            OP_EOR, OP_EORI:                fs = FS_XOR;
            OP_LSL:                         fs = FS_LSL;
            OP_LSR:                         fs = FS_LSR;
            default:                        fs = FS_AND;
        endcase
        return fs;
    endfunction

    function automatic logic sets_flags(input op_e op);
        return op inside {OP_ADDS, OP_SUBS, OP_ANDS,
                          OP_ADDIS, OP_SUBIS};
    endfunction

endpackage

// File: rtl/legv8_branch_cond.sv
// Evaluates an ARM-style condition code against the registered
// {V,C,N,Z} flags; purely combinational.
module legv8_branch_cond (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic v, c, n, z;

    assign {v, c, n, z} = flags;

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            4'h0: taken = z;
            4'h1: taken = !z;
            4'h2: taken = c;
            4'h3: taken = !c;
            4'h4: taken = n;
            4'h5: taken = !n;
            4'h6: taken = v;
            4'h7: taken = !v;
            4'h8: taken = c && !z;
            4'h9: taken = !(c && !z);
            4'hA: taken = (n == v);
            4'hB: taken = (n != v);
            4'hC: taken = !z && (n == v);
            4'hD: taken = !(!z && (n == v));
            4'hE, 4'hF: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 sequencer: latches the instruction, decodes it and
// drives one datapath control word per cycle.
module legv8_control_unit
    import legv8_control_unit_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [INST_W-1:0] instruction,
    input  logic [4:0]        status,
    output logic [CW_W-1:0]   control_word,
    output logic              halted
);

    state_e      state;
    logic [31:0] ir;
    op_e         op;
    cw_t         exe;
    cw_t         cw;
    logic        bcond_taken;
    logic        cb_taken;

    logic [4:0]  rd, rn, rm;
    logic [63:0] imm12, shamt, dofs, br26, br19;

    assign op    = decode_op(ir);
    assign rd    = ir[4:0];
    assign rn    = ir[9:5];
    assign rm    = ir[20:16];
    assign imm12 = {52'd0, ir[21:10]};
    assign shamt = {58'd0, ir[15:10]};
    assign dofs  = {{55{ir[20]}}, ir[20:12]};
    assign br26  = {{36{ir[25]}}, ir[25:0], 2'b00};
    assign br19  = {{43{ir[23]}}, ir[23:5], 2'b00};

    legv8_branch_cond u_bcond (
        .cond  (ir[3:0]),
        .flags (status[4:1]),
        .taken (bcond_taken)
    );

    assign cb_taken = (op == OP_CBZ) ? status[0] : !status[0];

    always_comb begin
        exe    = '0;
        exe.sa = rn;
        exe.da = rd;
        exe.fs = alu_fs(op);
        exe.sl = sets_flags(op);
        unique case (op)
            OP_ADD, OP_ADDS, OP_SUB, OP_SUBS,
            OP_AND, OP_ANDS, OP_ORR, OP_EOR: begin
                exe.sb     = rm;
                exe.en_alu = 1'b1;
                exe.wr     = 1'b1;
                exe.ps     = PS_PC4;
            end
            OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
            OP_ANDI, OP_ORRI, OP_EORI: begin
                exe.bsel     = 1'b1;
                exe.constant = imm12;
                exe.en_alu   = 1'b1;
                exe.wr       = 1'b1;
                exe.ps       = PS_PC4;
            end
            OP_LSL, OP_LSR: begin
                exe.bsel     = 1'b1;
                exe.constant = shamt;
                exe.en_alu   = 1'b1;
                exe.wr       = 1'b1;
                exe.ps       = PS_PC4;
            end
            OP_STUR: begin
                exe.sb       = rd;
                exe.bsel     = 1'b1;
                exe.constant = dofs;
                exe.wm       = 1'b1;
                exe.ps       = PS_PC4;
            end
            OP_LDUR: begin
                exe.bsel     = 1'b1;
                exe.constant = dofs;
                exe.ps       = PS_HOLD;
            end
            OP_B: begin
                exe.constant = br26;
                exe.ps       = PS_PCK;
            end
            OP_BL: begin
                exe.constant = br26;
                exe.en_pc    = 1'b1;
                exe.wr       = 1'b1;
                exe.da       = 5'd30;
                exe.ps       = PS_PCK;
            end
            OP_BR: begin
                exe.sa = rd;
                exe.ps = PS_PCA;
            end
            // Offset only appears once the live zero flag says taken.
            OP_CBZ, OP_CBNZ: begin
                exe.sa       = rd;
                exe.bsel     = 1'b1;
                exe.constant = cb_taken ? br19 : 64'd0;
                exe.ps       = cb_taken ? PS_PCK : PS_PC4;
            end
            OP_BCOND: begin
                exe.constant = br19;
                exe.ps       = bcond_taken ? PS_PCK : PS_PC4;
            end
            default: exe = '0;
        endcase
    end

    always_comb begin
        cw = '0;
        unique case (state)
            S_EXEC: cw = exe;
            S_LOAD2: begin
                cw.sa       = exe.sa;
                cw.fs       = exe.fs;
                cw.constant = exe.constant;
                cw.bsel     = exe.bsel;
                cw.en_mem   = 1'b1;
                cw.wr       = 1'b1;
                cw.da       = rd;
                cw.ps       = PS_PC4;
            end
            default: cw = '0;
        endcase
    end

    assign control_word = cw;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_FETCH;
            ir     <= '0;
            halted <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    ir    <= instruction;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (op == OP_BAD) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (op == OP_LDUR) begin
                        state <= S_LOAD2;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_LOAD2: state <= S_FETCH;
                S_HALT:  state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed-vector bench for legv8_control_unit with hand-computed
// control words.
module tb_legv8_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = '0;
    logic [4:0]  status = '0;
    logic [93:0] control_word;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] I_ADDI  = 32'h91001441;
    localparam logic [31:0] I_LDUR  = 32'hF8408083;
    localparam logic [31:0] I_SUBS  = 32'hEB0B0149;
    localparam logic [31:0] I_STUR  = 32'hF81F8107;
    localparam logic [31:0] I_CBZ   = 32'hB4000085;
    localparam logic [31:0] I_BLT   = 32'h5400010B;
    localparam logic [31:0] I_BL    = 32'h97FFFFFF;
    localparam logic [31:0] I_BR    = 32'hD600001E;

    legv8_control_unit dut (
        .clock        (clock),
        .reset        (reset),
        .instruction  (instruction),
        .status       (status),
        .control_word (control_word),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [95:0] got,
                       input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // en = {en_pc,en_mem,en_alu,pcsel,bsel,sl,wm,wr}
    function automatic logic [93:0] cw(input logic [63:0] k,
                                       input logic [7:0]  en,
                                       input logic [1:0]  ps,
                                       input logic [4:0]  fs,
                                       input logic [4:0]  sb,
                                       input logic [4:0]  sa,
                                       input logic [4:0]  da);
        return {k, en, ps, fs, sb, sa, da};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_cw", 96'(control_word), 96'd0);
        chk("rst_halted", 96'(halted), 96'd0);

        @(negedge clock);
        reset = 1'b0;
        instruction = I_ADDI;
        #1;
        chk("fetch0_cw", 96'(control_word), 96'd0);

        tick;
        chk("addi_cw", 96'(control_word),
            96'(cw(64'd5, 8'b0010_1001, 2'b01, 5'b01000,
                   5'd0, 5'd2, 5'd1)));
        chk("addi_ps", 96'(control_word[21:20]), 96'd1);

        tick;
        chk("fetch_cw", 96'(control_word), 96'd0);
        instruction = I_LDUR;
        tick;
        chk("ldur_exec_cw", 96'(control_word),
            96'(cw(64'd8, 8'b0000_1000, 2'b00, 5'b01000,
                   5'd0, 5'd4, 5'd3)));
        chk("ldur_exec_wr", 96'(control_word[22]), 96'd0);
        tick;
        chk("ldur_load2_cw", 96'(control_word),
            96'(cw(64'd8, 8'b0100_1001, 2'b01, 5'b01000,
                   5'd0, 5'd4, 5'd3)));
        tick;
        chk("ldur_back_fetch", 96'(control_word), 96'd0);

        instruction = I_SUBS;
        tick;
        chk("subs_cw", 96'(control_word),
            96'(cw(64'd0, 8'b0010_0101, 2'b01, 5'b01001,
                   5'd11, 5'd10, 5'd9)));

        tick;
        instruction = I_STUR;
        tick;
        chk("stur_cw", 96'(control_word),
            96'(cw(64'hFFFF_FFFF_FFFF_FFF8, 8'b0000_1010, 2'b01,
                   5'b01000, 5'd7, 5'd8, 5'd7)));

        tick;
        instruction = I_CBZ;
        status = 5'b00001;
        tick;
        chk("cbz_taken_cw", 96'(control_word),
            96'(cw(64'd16, 8'b0000_1000, 2'b10, 5'b00100,
                   5'd0, 5'd5, 5'd5)));
        status = 5'b00000;
        #1;
        chk("cbz_not_taken_cw", 96'(control_word),
            96'(cw(64'd0, 8'b0000_1000, 2'b01, 5'b00100,
                   5'd0, 5'd5, 5'd5)));

        tick;
        instruction = I_BLT;
        status = 5'b00100;
        tick;
        chk("blt_taken_ps", 96'(control_word[21:20]), 96'd2);
        chk("blt_taken_k", 96'(control_word[93:30]), 96'd32);
        chk("blt_wr", 96'(control_word[22]), 96'd0);
        status = 5'b10100;
        #1;
        chk("blt_not_taken_ps", 96'(control_word[21:20]), 96'd1);

        tick;
        instruction = I_BL;
        status = 5'b00000;
        tick;
        chk("bl_en", 96'(control_word[29:27]), 96'b100);
        chk("bl_wr", 96'(control_word[22]), 96'd1);
        chk("bl_da", 96'(control_word[4:0]), 96'd30);
        chk("bl_ps", 96'(control_word[21:20]), 96'd2);
        chk("bl_k", 96'(control_word[93:30]),
            96'(64'hFFFF_FFFF_FFFF_FFFC));

        tick;
        instruction = I_BR;
        tick;
        chk("br_ps", 96'(control_word[21:20]), 96'd3);
        chk("br_sa", 96'(control_word[9:5]), 96'd30);
        chk("br_wr", 96'(control_word[22]), 96'd0);

        tick;
        instruction = I_LDUR;
        tick;
        tick;
        chk("load2_en_mem", 96'(control_word[28]), 96'd1);
        #2 reset = 1'b1;
        #1;
        chk("midreset_cw", 96'(control_word), 96'd0);
        chk("midreset_halted", 96'(halted), 96'd0);

        @(negedge clock);
        reset = 1'b0;
        instruction = 32'h0000_0000;
        tick;
        chk("bad_exec_cw", 96'(control_word), 96'd0);
        chk("bad_exec_halted", 96'(halted), 96'd0);
        tick;
        for (int i = 0; i < 10; i++) begin
            chk("halt_cw", 96'(control_word), 96'd0);
            chk("halt_halted", 96'(halted), 96'd1);
            tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
